// File: rtl/if_id_stage_if.sv
// Signal bundle between fetch/hazard sources and the IF/ID stage.
// IFID_PERF_CNT_EN adds the stallCount/flushCount performance counters.
interface if_id_stage_if #(
  parameter int DATA_WIDTH = 16,
  parameter int REG_ADDR_W = 3
);
  logic [DATA_WIDTH-1:0] PC4;
  logic [DATA_WIDTH-1:0] instruction;
  logic                  branchTaken;
  logic                  idexMemRead;
  logic [REG_ADDR_W-1:0] idexRt;
  logic [DATA_WIDTH-1:0] outputPC4;
  logic [DATA_WIDTH-1:0] outputInstruction;
  logic                  validOut;
  logic                  pcWrite;
  logic                  bubble;
`ifdef IFID_PERF_CNT_EN
  logic [15:0]           stallCount;
  logic [15:0]           flushCount;
`endif

  modport master (
    output PC4, instruction, branchTaken, idexMemRead, idexRt,
`ifdef IFID_PERF_CNT_EN
    input  stallCount, flushCount,
`endif
    input  outputPC4, outputInstruction, validOut, pcWrite, bubble
  );

  modport slave (
    input  PC4, instruction, branchTaken, idexMemRead, idexRt,
`ifdef IFID_PERF_CNT_EN
    output stallCount, flushCount,
`endif
    output outputPC4, outputInstruction, validOut, pcWrite, bubble
  );
endinterface

// File: rtl/if_id_stage.sv
// IF/ID pipeline register (negedge) with load-use stall FSM and branch flush.
// Define IFID_PERF_CNT_EN to build the saturating stall/flush counters.
module if_id_stage #(
  parameter int                    DATA_WIDTH = 16,
  parameter int                    REG_ADDR_W = 3,
  parameter int                    RS_LSB     = 9,
  parameter int                    RT_LSB     = 6,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = 16'h0000
) (
  input  logic          clock,
  input  logic          reset,
  if_id_stage_if.slave  bus
);

  typedef enum logic {RUN = 1'b0, STALL = 1'b1} stateT;

  stateT                 state;
  stateT                 nextState;
  logic [DATA_WIDTH-1:0] pc4Reg;
  logic [DATA_WIDTH-1:0] instrReg;
  logic                  validReg;
  logic [REG_ADDR_W-1:0] rsField;
  logic [REG_ADDR_W-1:0] rtField;
  logic                  hazard;
  logic                  stallReq;

  // Hazard compare against the held instruction; register 0 is deliberately not excluded
  always_comb begin
    rsField   = instrReg[RS_LSB +: REG_ADDR_W];
    rtField   = instrReg[RT_LSB +: REG_ADDR_W];
    hazard    = validReg & bus.idexMemRead &
                ((bus.idexRt == rsField) | (bus.idexRt == rtField));
    stallReq  = 1'b0;
    nextState = RUN;
    case (state)
      RUN: begin
        stallReq = hazard;
        if (bus.branchTaken) begin
          nextState = RUN;
        end else if (hazard) begin
          nextState = STALL;
        end else begin
          nextState = RUN;
        end
      end
      STALL:   nextState = RUN;
      default: nextState = RUN;
    endcase
  end

  // FSM state register
  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      state <= RUN;
    end else begin
      state <= nextState;
    end
  end

  // Pipeline data registers: flush beats stall, stall holds everything
  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      pc4Reg   <= '0;
      instrReg <= NOP_INSTR;
      validReg <= 1'b0;
    end else if (bus.branchTaken) begin
      pc4Reg   <= bus.PC4;
      instrReg <= NOP_INSTR;
      validReg <= 1'b0;
    end else if (!stallReq) begin
      pc4Reg   <= bus.PC4;
      instrReg <= bus.instruction;
      validReg <= 1'b1;
    end
  end

`ifdef IFID_PERF_CNT_EN
  // Saturating performance counters, cleared only by reset
  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      bus.stallCount <= 16'h0000;
      bus.flushCount <= 16'h0000;
    end else if (bus.branchTaken) begin
      if (bus.flushCount != 16'hFFFF) begin
        bus.flushCount <= bus.flushCount + 16'h0001;
      end
    end else if (stallReq) begin
      if (bus.stallCount != 16'hFFFF) begin
        bus.stallCount <= bus.stallCount + 16'h0001;
      end
    end
  end
`endif

  assign bus.outputPC4         = pc4Reg;
  assign bus.outputInstruction = instrReg;
  assign bus.validOut          = validReg;
  assign bus.pcWrite           = ~stallReq;
  assign bus.bubble            = stallReq;

endmodule
